// File: rtl/adder_accumulator_if.sv
// rtl/adder_accumulator_if.sv - sample/total handshake bundle for the adder accumulator stage
interface adder_accumulator_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 12
);
  // Upstream sample side
  logic                 i_valid;
  logic                 o_ready;
  logic [WIDTH-1:0]     i_S;
  logic                 i_carry;
  // Batch control
  logic                 i_clear;
  // Downstream total side
  logic                 o_valid;
  logic                 i_ready;
  logic [ACC_WIDTH-1:0] o_acc;
  logic                 o_ovf;
  logic                 o_busy;

  // The accumulator stage itself
  modport slave (
    input  i_valid, i_S, i_carry, i_clear, i_ready,
    output o_ready, o_valid, o_acc, o_ovf, o_busy
  );

  // The environment driving samples and consuming totals
  modport master (
    output i_valid, i_S, i_carry, i_clear, i_ready,
    input  o_ready, o_valid, o_acc, o_ovf, o_busy
  );
endinterface

// File: rtl/adder_accumulator.sv
// rtl/adder_accumulator.sv - batches COUNT {carry,sum} adder results into a wrapped total with overflow flag
module adder_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 12,
  parameter int COUNT     = 8
) (
  input logic            i_clk,
  input logic            i_rst,
  adder_accumulator_if.slave bus
);

  // A counter that can hold COUNT itself, so COUNT==1 still gets a 1-bit counter.
  localparam int CNT_W = $clog2(COUNT + 1);
  // Count value seen in ACCUM just before the final sample of a batch is added.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;
  logic                 valid_q;
  logic                 ready_q;
  logic                 busy_q;

  logic [ACC_WIDTH-1:0] sample;
  logic [ACC_WIDTH:0]   sum;
  logic                 accept;

  // Zero-extend the adder result {carry, sum}; it can never exceed WIDTH+1 bits.
  assign sample = ACC_WIDTH'({bus.i_carry, bus.i_S});

  // One bit wider than the accumulator so the wrap shows up as the top bit.
  assign sum = {1'b0, acc} + {1'b0, sample};

  // A sample is taken whenever we are not holding a finished total.
  assign accept = bus.i_valid & ready_q;

  // Batch FSM; flags follow the state so every output comes straight from a flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else if (bus.i_clear) begin
      // Abort wins over everything: drop the partial batch, any offered sample and any held total.
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= sample;
            cnt <= CNT_ONE;
            ovf <= 1'b0;
            if (COUNT == 1) begin
              state   <= DONE;
              valid_q <= 1'b1;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              state   <= ACCUM;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (accept) begin
            acc <= sum[ACC_WIDTH-1:0];
            cnt <= cnt + CNT_ONE;
            // Sticky: once the batch has wrapped it stays flagged until the next batch starts.
            if (sum[ACC_WIDTH]) begin
              ovf <= 1'b1;
            end
            if (cnt == CNT_LAST) begin
              state   <= DONE;
              valid_q <= 1'b1;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end

        DONE: begin
          // Total and overflow stay frozen until taken; ovf survives into IDLE for late readers.
          if (bus.i_ready) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          acc     <= '0;
          cnt     <= '0;
          ovf     <= 1'b0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_acc   = acc;
  assign bus.o_ovf   = ovf;

endmodule

// File: tb/tb_adder_accumulator.sv
// tb/tb_adder_accumulator.sv - scoreboard bench for three adder_accumulator configurations
module tb_adder_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] s_in = 4'd0;
  logic       carry = 1'b0;
  logic       clear = 1'b0;
  logic       ready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Lane 0: defaults, lane 1: ACC_WIDTH=7, lane 2: COUNT=1
  adder_accumulator_if #(.WIDTH(4), .ACC_WIDTH(12)) if0 ();
  adder_accumulator_if #(.WIDTH(4), .ACC_WIDTH(7))  if1 ();
  adder_accumulator_if #(.WIDTH(4), .ACC_WIDTH(12)) if2 ();

  adder_accumulator #(.WIDTH(4), .ACC_WIDTH(12), .COUNT(8)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  adder_accumulator #(.WIDTH(4), .ACC_WIDTH(7),  .COUNT(8)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
  adder_accumulator #(.WIDTH(4), .ACC_WIDTH(12), .COUNT(1)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

  assign if0.i_valid = valid; assign if0.i_S = s_in; assign if0.i_carry = carry;
  assign if0.i_clear = clear; assign if0.i_ready = ready;
  assign if1.i_valid = valid; assign if1.i_S = s_in; assign if1.i_carry = carry;
  assign if1.i_clear = clear; assign if1.i_ready = ready;
  assign if2.i_valid = valid; assign if2.i_S = s_in; assign if2.i_carry = carry;
  assign if2.i_clear = clear; assign if2.i_ready = ready;

  logic [2:0]  ov, ordy, obusy, oovf;
  logic [11:0] oacc [3];
  assign ov    = {if2.o_valid, if1.o_valid, if0.o_valid};
  assign ordy  = {if2.o_ready, if1.o_ready, if0.o_ready};
  assign obusy = {if2.o_busy,  if1.o_busy,  if0.o_busy};
  assign oovf  = {if2.o_ovf,   if1.o_ovf,   if0.o_ovf};
  assign oacc[0] = if0.o_acc;
  assign oacc[1] = {5'd0, if1.o_acc};
  assign oacc[2] = if2.o_acc;

  // Reference model: list-of-samples view of each batch, exact integer sum
  int  n_m   [3];
  int  sum_m [3];
  bit  done_m[3];
  bit  ovf_m [3];
  logic [12:0] q0[$], q1[$], q2[$];

  function automatic int lim(input int l);
    return (l == 1) ? 128 : 4096;
  endfunction

  function automatic int cnt_of(input int l);
    return (l == 2) ? 1 : 8;
  endfunction

  function automatic int qsize(input int l);
    case (l)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic q_push(input int l, input logic [12:0] e);
    case (l)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic q_drop(input int l);
    case (l)
      0: if (q0.size() > 0) void'(q0.pop_back());
      1: if (q1.size() > 0) void'(q1.pop_back());
      default: if (q2.size() > 0) void'(q2.pop_back());
    endcase
  endtask

  task automatic q_pop(input int l, output logic [12:0] e);
    case (l)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 3; l++) begin
      n_m[l] = 0; sum_m[l] = 0; done_m[l] = 1'b0; ovf_m[l] = 1'b0;
    end
    q0.delete(); q1.delete(); q2.delete();
  endtask

  // Apply the inputs present at a rising edge to every lane's model
  task automatic model_step();
    int v;
    v = {carry, s_in};
    for (int l = 0; l < 3; l++) begin
      if (clear) begin
        if (done_m[l]) q_drop(l);
        done_m[l] = 1'b0; n_m[l] = 0; sum_m[l] = 0; ovf_m[l] = 1'b0;
      end else if (done_m[l]) begin
        if (ready) begin
          done_m[l] = 1'b0; n_m[l] = 0; sum_m[l] = 0;
        end
      end else if (valid) begin
        sum_m[l] = sum_m[l] + v;
        n_m[l]   = n_m[l] + 1;
        ovf_m[l] = (sum_m[l] >= lim(l));
        if (n_m[l] == cnt_of(l)) begin
          done_m[l] = 1'b1;
          q_push(l, {ovf_m[l], 12'(sum_m[l] % lim(l))});
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] s, input logic c,
                       input logic clr, input logic rdy);
    valid = v; s_in = s; carry = c; clear = clr; ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_busy",  obusy[0], 0);
    chk("rst_async_valid", ov[0], 0);
    chk("rst_async_acc",   oacc[0], 0);
    chk("rst_async_ready", ordy[0], 1);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: per-cycle state checks plus scoreboard pop on each accepted total
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        chk($sformatf("valid_l%0d", l), ov[l],    done_m[l]);
        chk($sformatf("ready_l%0d", l), ordy[l],  !done_m[l]);
        chk($sformatf("busy_l%0d", l),  obusy[l], (n_m[l] > 0) && !done_m[l]);
        chk($sformatf("ovf_l%0d", l),   oovf[l],  ovf_m[l]);
        if (done_m[l]) chk($sformatf("held_acc_l%0d", l), oacc[l], sum_m[l] % lim(l));
        if (!rst && ov[l] && ready && !clear) begin
          chk($sformatf("sb_depth_l%0d", l), qsize(l), 1);
          if (qsize(l) > 0) begin
            q_pop(l, e);
            chk($sformatf("total_acc_l%0d", l), oacc[l], e[11:0]);
            chk($sformatf("total_ovf_l%0d", l), oovf[l], e[12]);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_valid", ov[0], 0);
    chk("reset_ready", ordy[0], 1);
    chk("reset_busy",  obusy[0], 0);
    chk("reset_acc",   oacc[0], 0);
    chk("reset_ovf",   oovf[0], 0);

    // 8 x 31 with ready high
    repeat (8) cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b1);
    chk("t1_valid", ov[0], 1);
    chk("t1_acc",   oacc[0], 248);
    chk("t1_ovf",   oovf[0], 0);
    chk("t3_acc",   oacc[1], 120);
    chk("t3_ovf",   oovf[1], 1);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("t1_handshake", ov[0], 0);

    // Backpressure: total held, offered samples refused
    repeat (8) cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
      chk("t2_valid", ov[0], 1);
      chk("t2_acc",   oacc[0], 248);
      chk("t2_ready", ordy[0], 0);
    end
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_idle_valid", ov[0], 0);
    chk("t2_idle_busy",  obusy[0], 0);

    // Small batch after a wrapped one: ovf clears on new batch
    repeat (8) cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b1);
    chk("t3b_acc", oacc[1], 8);
    chk("t3b_ovf", oovf[1], 0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Clear after 3 accepts with a sample offered in the same cycle
    repeat (3) cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'h2, 1'b0, 1'b1, 1'b1);
    chk("t4_busy", obusy[0], 0);
    chk("t4_acc",  oacc[0], 0);
    repeat (8) cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b1);
    chk("t4_total", oacc[0], 16);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-batch, then a fresh batch
    repeat (3) cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    rst_pulse();
    repeat (8) cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    chk("t5_total", oacc[0], 24);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);

    // COUNT=1 lane: a total every two cycles
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    chk("t6_valid1", ov[2], 1);
    chk("t6_acc",    oacc[2], 5);
    cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    chk("t6_gap", ov[2], 0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    chk("t6_valid2", ov[2], 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, 4'($urandom), 1'($urandom),
            $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6);
    end

    // Drain outstanding totals
    repeat (3) cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int l = 0; l < 3; l++) chk($sformatf("drain_l%0d", l), qsize(l), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
